// File: rtl/nios_system_processor1_cpu_debug_mem_responder.sv
// Debug-memory command responder: turns JTAG ocimem strobes into single word accesses on an Avalon-MM master.
// Optional wait-state abort is enabled by defining DEBUG_MEM_TIMEOUT_EN.
module nios_system_processor1_cpu_debug_mem_responder #(
   parameter int ADDR_W         = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   output logic              mem_write,
   output logic [31:0]       mem_writedata,
   input  logic [31:0]       mem_readdata,
   input  logic              mem_waitrequest,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, RD, WR} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] areg_q, areg_d;
   logic [ADDR_W-1:0] mem_address_q, mem_address_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [31:0]       mem_writedata_q, mem_writedata_d;
   logic [31:0]       mon_dreg_q, mon_dreg_d;
   logic              monitor_ready_q, monitor_ready_d;
   logic              monitor_error_q, monitor_error_d;
   logic              busy_q, busy_d;

   logic in_idle, do_cmd, do_data, do_cont, is_write, done, abort;
   logic unused_ok;

`ifdef DEBUG_MEM_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   assign abort     = !in_idle && mem_waitrequest && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign unused_ok = ^{jdo[37:36], jdo[2:0]};
`else
   assign abort     = 1'b0;
   assign unused_ok = ^{jdo[37:36], jdo[2:0], (TIMEOUT_CYCLES != 0)};
`endif

   // Strobe priority: a > b > no_action; lower ones are simply ignored when masked.
   assign in_idle  = (state_q == IDLE);
   assign do_cmd   = take_action_ocimem_a;
   assign do_data  = !take_action_ocimem_a && take_action_ocimem_b;
   assign do_cont  = !take_action_ocimem_a && !take_action_ocimem_b && take_no_action_ocimem_a;
   assign is_write = do_data && jdo[35];
   assign done     = !in_idle && !mem_waitrequest;

   always_comb begin
      state_d         = state_q;
      areg_d          = areg_q;
      mem_address_d   = mem_address_q;
      mem_read_d      = mem_read_q;
      mem_write_d     = mem_write_q;
      mem_writedata_d = mem_writedata_q;
      mon_dreg_d      = mon_dreg_q;
      monitor_ready_d = monitor_ready_q;
      monitor_error_d = monitor_error_q;
      busy_d          = busy_q;
`ifdef DEBUG_MEM_TIMEOUT_EN
      wait_cnt_d      = wait_cnt_q;
`endif

      if (do_cmd) begin
         if (jdo[35]) monitor_ready_d = 1'b0;
         if (jdo[34]) monitor_error_d = 1'b0;
         if (jdo[25] && in_idle) areg_d = jdo[17+ADDR_W-1:17];
      end

      if (in_idle) begin
         if (do_data || do_cont) begin
            state_d         = is_write ? WR : RD;
            busy_d          = 1'b1;
            monitor_ready_d = 1'b0;
            mem_address_d   = areg_q;
            mem_read_d      = !is_write;
            mem_write_d     = is_write;
            if (is_write) begin
               mem_writedata_d = jdo[34:3];
               mon_dreg_d      = jdo[34:3];
            end
`ifdef DEBUG_MEM_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
         end
      end else begin
         // The access in flight keeps going; the late strobe is only flagged.
         if (do_data || do_cont) monitor_error_d = 1'b1;
         if (done || abort) begin
            mem_read_d      = 1'b0;
            mem_write_d     = 1'b0;
            busy_d          = 1'b0;
            monitor_ready_d = 1'b1;
            state_d         = IDLE;
            if (done) begin
               if (state_q == RD) mon_dreg_d = mem_readdata;
               areg_d = areg_q + 1'b1;
            end else begin
               monitor_error_d = 1'b1;
            end
         end
`ifdef DEBUG_MEM_TIMEOUT_EN
         else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         areg_q          <= '0;
         mem_address_q   <= '0;
         mem_read_q      <= 1'b0;
         mem_write_q     <= 1'b0;
         mem_writedata_q <= '0;
         mon_dreg_q      <= '0;
         monitor_ready_q <= 1'b0;
         monitor_error_q <= 1'b0;
         busy_q          <= 1'b0;
`ifdef DEBUG_MEM_TIMEOUT_EN
         wait_cnt_q      <= '0;
`endif
      end else begin
         state_q         <= state_d;
         areg_q          <= areg_d;
         mem_address_q   <= mem_address_d;
         mem_read_q      <= mem_read_d;
         mem_write_q     <= mem_write_d;
         mem_writedata_q <= mem_writedata_d;
         mon_dreg_q      <= mon_dreg_d;
         monitor_ready_q <= monitor_ready_d;
         monitor_error_q <= monitor_error_d;
         busy_q          <= busy_d;
`ifdef DEBUG_MEM_TIMEOUT_EN
         wait_cnt_q      <= wait_cnt_d;
`endif
      end
   end

   assign mem_address   = mem_address_q;
   assign mem_read      = mem_read_q;
   assign mem_write     = mem_write_q;
   assign mem_writedata = mem_writedata_q;
   assign MonDReg       = mon_dreg_q;
   assign monitor_ready = monitor_ready_q;
   assign monitor_error = monitor_error_q;
   assign busy          = busy_q;

endmodule
